// File: rtl/seq_detect_param_if.sv
// Serial detector bus: qualified data bit, counter clear, match flag and
// debug state, grouped for master (stream source) and slave (detector).
interface seq_detect_param_if #(
    parameter int CNT_W = 8,
    parameter int SW    = 2
);
    logic             en;
    logic             seq_in;
    logic             clr_cnt;
    logic             seq_out;
    logic [CNT_W-1:0] match_cnt;
    logic [SW-1:0]    crnt_state;

    modport master (
        output en, seq_in, clr_cnt,
        input  seq_out, match_cnt, crnt_state
    );

    modport slave (
        input  en, seq_in, clr_cnt,
        output seq_out, match_cnt, crnt_state
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector (Moore or Mealy, optional overlap)
// with KMP transitions built at elaboration and a saturating match counter.
module seq_detect_param #(
    parameter int               SEQ_LEN = 3,
    parameter logic [SEQ_LEN-1:0] PATTERN = 3'b101,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MEALY   = 1'b0,
    parameter int               CNT_W   = 8,
    localparam int              SW      = $clog2(SEQ_LEN + 1)
) (
    input  logic clk,
    input  logic reset,
    seq_detect_param_if.slave bus
);
    localparam int NST    = 2 ** SW;
    localparam int TBW    = 2 * NST * SW;
    localparam int MAX_ST = MEALY ? SEQ_LEN - 1 : SEQ_LEN;

    localparam logic [SW-1:0] MAX_Q  = SW'(MAX_ST);
    localparam logic [SW-1:0] SEQ_Q  = SW'(SEQ_LEN);
    localparam logic [SW-1:0] LAST_Q = SW'(SEQ_LEN - 1);

    // First l pattern bits, first-received bit as MSB.
    function automatic int pfx(int l);
        return int'(PATTERN) >> (SEQ_LEN - l);
    endfunction

    // Longest pattern prefix (<= maxl) ending the n-bit string s.
    function automatic int lps(int s, int n, int maxl);
        int r;
        r = 0;
        for (int l = 1; l <= maxl; l++) begin
            if (l <= n && (s & ((1 << l) - 1)) == pfx(l)) r = l;
        end
        return r;
    endfunction

    function automatic int delta(int k, int b);
        return lps((pfx(k) << 1) | b, k + 1, SEQ_LEN);
    endfunction

    // Next-state table indexed by {state, bit}; unused codes map to 0.
    function automatic logic [TBW-1:0] build_tbl();
        logic [TBW-1:0] t;
        int f;
        int n;
        t = '0;
        f = lps(int'(PATTERN), SEQ_LEN, SEQ_LEN - 1);
        for (int k = 0; k <= SEQ_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                if (k < SEQ_LEN) begin
                    n = delta(k, b);
                    if (MEALY && n == SEQ_LEN) n = OVERLAP ? f : 0;
                end else if (MEALY) begin
                    n = 0;
                end else if (OVERLAP) begin
                    n = delta(f, b);
                end else begin
                    n = (b == int'(PATTERN[SEQ_LEN-1])) ? 1 : 0;
                end
                t[(2 * k + b) * SW +: SW] = n[SW-1:0];
            end
        end
        return t;
    endfunction

    localparam logic [TBW-1:0] TBL = build_tbl();

    logic [SW-1:0]    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    nxt;
    logic [SW:0]      idx;
    logic             hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;
        idx     = {state_q, bus.seq_in};
        nxt     = TBL[int'(idx) * SW +: SW];
        if (state_q > MAX_Q) begin
            state_d = '0;
        end else if (bus.en) begin
            state_d = nxt;
            if (MEALY) hit = (state_q == LAST_Q) && (bus.seq_in == PATTERN[0]);
            else       hit = (nxt == SEQ_Q);
        end
        if (bus.clr_cnt)                 cnt_d = '0;
        else if (hit && cnt_q != '1)     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.seq_out    = MEALY ? hit : (state_q == SEQ_Q);
    assign bus.match_cnt  = cnt_q;
    assign bus.crnt_state = state_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: five configurations share one stimulus stream,
// checked against directed tables and a history-based reference model.
module tb_seq_detect_param;
    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic sin = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.CNT_W(8), .SW(2)) if0 ();
    seq_detect_param_if #(.CNT_W(8), .SW(2)) if1 ();
    seq_detect_param_if #(.CNT_W(8), .SW(3)) if2 ();
    seq_detect_param_if #(.CNT_W(2), .SW(2)) if3 ();
    seq_detect_param_if #(.CNT_W(8), .SW(3)) if4 ();

    assign if0.en = en; assign if0.seq_in = sin; assign if0.clr_cnt = clr;
    assign if1.en = en; assign if1.seq_in = sin; assign if1.clr_cnt = clr;
    assign if2.en = en; assign if2.seq_in = sin; assign if2.clr_cnt = clr;
    assign if3.en = en; assign if3.seq_in = sin; assign if3.clr_cnt = clr;
    assign if4.en = en; assign if4.seq_in = sin; assign if4.clr_cnt = clr;

    seq_detect_param u0 (.clk(clk), .reset(rst), .bus(if0));
    seq_detect_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .reset(rst), .bus(if1));
    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1101), .MEALY(1'b1))
        u2 (.clk(clk), .reset(rst), .bus(if2));
    seq_detect_param #(.CNT_W(2)) u3 (.clk(clk), .reset(rst), .bus(if3));
    seq_detect_param #(.SEQ_LEN(5), .PATTERN(5'b10100), .OVERLAP(1'b0),
        .MEALY(1'b1)) u4 (.clk(clk), .reset(rst), .bus(if4));

    int p_len [NI] = '{3, 3, 4, 3, 5};
    int p_pat [NI] = '{5, 5, 13, 5, 20};
    int p_ovl [NI] = '{1, 0, 1, 1, 0};
    int p_mly [NI] = '{0, 0, 1, 0, 1};
    int p_max [NI] = '{255, 255, 255, 3, 255};

    logic [NI-1:0] so_v;
    int st_v  [NI];
    int cnt_v [NI];

    always_comb begin
        so_v = {if4.seq_out, if3.seq_out, if2.seq_out, if1.seq_out, if0.seq_out};
        st_v[0] = int'(if0.crnt_state); cnt_v[0] = int'(if0.match_cnt);
        st_v[1] = int'(if1.crnt_state); cnt_v[1] = int'(if1.match_cnt);
        st_v[2] = int'(if2.crnt_state); cnt_v[2] = int'(if2.match_cnt);
        st_v[3] = int'(if3.crnt_state); cnt_v[3] = int'(if3.match_cnt);
        st_v[4] = int'(if4.crnt_state); cnt_v[4] = int'(if4.match_cnt);
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Model: last received bits since reset (or since a non-overlapping
    // match); state is the longest pattern prefix ending that history.
    int m_hist [NI];
    int m_hlen [NI];
    int m_st   [NI];
    int m_cnt  [NI];
    bit pre_out [NI];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int longest(int i, int h, int n, int maxl);
        int r;
        r = 0;
        for (int l = 1; l <= maxl && l <= n; l++) begin
            if ((h & ((1 << l) - 1)) == (p_pat[i] >> (p_len[i] - l))) r = l;
        end
        return r;
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit mealy_exp(int i, bit e, bit b);
        int n;
        n = min2(m_hlen[i] + 1, p_len[i]);
        return e && longest(i, (m_hist[i] << 1) | int'(b), n, p_len[i]) == p_len[i];
    endfunction

    task automatic model_upd(input int i, input bit r, e, b, c);
        int h, n, l;
        bit m;
        if (!r) begin
            m_hist[i] = 0; m_hlen[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
        end else begin
            m = 1'b0;
            if (e) begin
                h = ((m_hist[i] << 1) | int'(b)) & 32'hFFFF;
                n = min2(m_hlen[i] + 1, p_len[i]);
                l = longest(i, h, n, p_len[i]);
                m = (l == p_len[i]);
                m_st[i] = l;
                if (m && p_ovl[i] == 0) begin
                    n = 0;
                    if (p_mly[i] != 0) m_st[i] = 0;
                end else if (m) begin
                    if (p_mly[i] != 0) m_st[i] = longest(i, h, n, p_len[i] - 1);
                end
                m_hist[i] = h;
                m_hlen[i] = n;
            end
            if (c) m_cnt[i] = 0;
            else if (m && m_cnt[i] < p_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic step(input bit r, e, b, c);
        @(negedge clk);
        rst = r; en = e; sin = b; clr = c;
        #1;
        for (int i = 0; i < NI; i++) begin
            pre_out[i] = so_v[i];
            if (p_mly[i] != 0 && r)
                chk($sformatf("mealy_out[%0d]", i), int'(so_v[i]),
                    int'(mealy_exp(i, e, b)));
        end
        for (int i = 0; i < NI; i++) model_upd(i, r, e, b, c);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("state[%0d]", i), st_v[i], m_st[i]);
            chk($sformatf("cnt[%0d]", i), cnt_v[i], m_cnt[i]);
            if (p_mly[i] == 0)
                chk($sformatf("moore_out[%0d]", i), int'(so_v[i]),
                    int'(m_st[i] == p_len[i]));
        end
    endtask

    typedef struct {
        int inst;
        bit r, e, b, c;
        int st;
        bit out;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int inst, bit r, e, b, c, int st, bit out, int cnt);
        vec_t v;
        v.inst = inst; v.r = r; v.e = e; v.b = b; v.c = c;
        v.st = st; v.out = out; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin
        // Default 101 Moore overlap: reset 2 clks, then 1,0,1,0,1
        add(0,0,0,0,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
        add(0,1,1,1,0, 1,0,0); add(0,1,1,0,0, 2,0,0);
        add(0,1,1,1,0, 3,1,1); add(0,1,1,0,0, 2,0,1);
        add(0,1,1,1,0, 3,1,2);
        // Non-overlapping: 1,0,1,0,1,0,1
        add(1,0,0,0,0, 0,0,0);
        add(1,1,1,1,0, 1,0,0); add(1,1,1,0,0, 2,0,0);
        add(1,1,1,1,0, 3,1,1); add(1,1,1,0,0, 0,0,1);
        add(1,1,1,1,0, 1,0,1); add(1,1,1,0,0, 2,0,1);
        add(1,1,1,1,0, 3,1,2);
        // Mealy 1101 overlap: 1,1,1,0,1,1,0,1 (out is same-cycle)
        add(2,0,0,0,0, 0,0,0);
        add(2,1,1,1,0, 1,0,0); add(2,1,1,1,0, 2,0,0);
        add(2,1,1,1,0, 2,0,0); add(2,1,1,0,0, 3,0,0);
        add(2,1,1,1,0, 1,1,1); add(2,1,1,1,0, 2,0,1);
        add(2,1,1,0,0, 3,0,1); add(2,1,1,1,0, 1,1,2);
        // en gaps: bits 1,0,1 with 3 idle cycles after each
        add(0,0,0,0,0, 0,0,0);
        add(0,1,1,1,0, 1,0,0);
        for (int j = 0; j < 3; j++) add(0,1,0,0,0, 1,0,0);
        add(0,1,1,0,0, 2,0,0);
        for (int j = 0; j < 3; j++) add(0,1,0,1,0, 2,0,0);
        add(0,1,1,1,0, 3,1,1);
        for (int j = 0; j < 3; j++) add(0,1,0,0,0, 3,1,1);
        // Reset mid-pattern overrides en
        add(0,0,0,0,0, 0,0,0); add(0,1,1,1,0, 1,0,0);
        add(0,1,1,0,0, 2,0,0); add(0,0,1,1,0, 0,0,0);
        add(0,1,1,1,0, 1,0,0);

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].e, tbl[k].b, tbl[k].c);
            chk($sformatf("tbl%0d_state", k), st_v[tbl[k].inst], tbl[k].st);
            chk($sformatf("tbl%0d_cnt", k), cnt_v[tbl[k].inst], tbl[k].cnt);
            chk($sformatf("tbl%0d_out", k),
                p_mly[tbl[k].inst] != 0 ? int'(pre_out[tbl[k].inst])
                                        : int'(so_v[tbl[k].inst]),
                int'(tbl[k].out));
        end

        // CNT_W=2 saturation, then clear on the same edge as a match
        step(0, 0, 0, 0);
        for (int j = 0; j < 11; j++) begin
            step(1, 1, (j % 2) == 0, 0);
            if (j == 6) chk("sat_cnt_3rd", cnt_v[3], 3);
        end
        chk("sat_cnt_hold", cnt_v[3], 3);
        chk("sat_state", st_v[3], 3);
        step(1, 1, 0, 0);
        step(1, 1, 1, 1);
        chk("clr_on_match_cnt", cnt_v[3], 0);
        chk("clr_on_match_state", st_v[3], 3);
        chk("clr_on_match_out", int'(so_v[3]), 1);

        // Random stream against the reference model
        for (int j = 0; j < 3000; j++) begin
            bit r, e, b, c;
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 3) != 0);
            b = 1'($urandom);
            c = e && ($urandom_range(0, 19) == 0);
            step(r, e, b, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector. It is the next generation of the fixed 3-bit "101" Mealy/Moore detector FSM.
- Pattern, pattern length, overlap policy and output style (Moore registered / Mealy combinational) are set by parameters.
- Adds an input-qualifying enable and a saturating match counter.
- Sits on a serial bit stream (UART/line decoder side) and flags each occurrence of the pattern.

Parameters:
SEQ_LEN, 3, pattern length in bits, legal range 2..16.
PATTERN, 3'b101, SEQ_LEN-bit pattern. PATTERN[SEQ_LEN-1] is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = detection restarts after each match.
MEALY, 0, 0 = Moore (seq_out decoded from state); 1 = Mealy (seq_out combinational from state and seq_in).
CNT_W, 8, width of match counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset; sampled on rising clk.
en  input  1  seq_in is valid this cycle. When low, the FSM and counter hold.
seq_in  input  1  serial data bit.
clr_cnt  input  1  synchronous clear of match_cnt.
seq_out  output  1  match flag.
match_cnt  output  CNT_W  saturating count of matches since reset/clear.
crnt_state  output  SW  current state, SW = $clog2(SEQ_LEN+1). Used for debug and bench visibility.

Behaviour:
- Only clock: clk. Reset is synchronous, active-low: reset==0 at a rising clk forces crnt_state=0 and match_cnt=0. It overrides en and clr_cnt, including mid-pattern.
- State k (0..SEQ_LEN-1, plus SEQ_LEN in Moore only) = number of pattern prefix bits currently matched. Expected next bit in state k is E(k) = PATTERN[SEQ_LEN-1-k].
- Transition delta(k,b) for k<SEQ_LEN:
  - b==E(k): go to k+1.
  - otherwise: go to the longest proper prefix of the pattern that is a suffix of (matched prefix k followed by b). This is KMP failure; it can be 0.
  - Failure table is computed at elaboration (function/generate), not hard-coded.
- Moore (MEALY=0):
  - Reaching k+1==SEQ_LEN enters state SEQ_LEN.
  - seq_out = (crnt_state==SEQ_LEN): high exactly one cycle after the final pattern bit is sampled, for one en-cycle. It stays high while en is low.
  - From state SEQ_LEN with en:
    - OVERLAP=1: next = delta(F, b), where F = failure length of the full pattern.
    - OVERLAP=0: next = (b==E(0)) ? 1 : 0.
- Mealy (MEALY=1):
  - State SEQ_LEN is never entered.
  - seq_out = en && crnt_state==SEQ_LEN-1 && seq_in==E(SEQ_LEN-1). This is combinational, in the same cycle as the final bit.
  - On that match, next = OVERLAP ? F : 0.
- en=0: crnt_state holds; no match is counted; Mealy seq_out=0.
- match_cnt:
  - Increments by 1 on each detected match event. Moore: the cycle of entry into SEQ_LEN. Mealy: the Mealy-match cycle.
  - Saturates at 2^CNT_W-1, no wrap.
  - clr_cnt on the same edge as a match: the result is 0 (clear wins).
- Illegal state encodings (> max state): next state = 0, seq_out = 0.
- No X propagation: all outputs are defined from the first edge after reset.

Test Plan:
1. Defaults (101, overlap, Moore); reset low for 2 clks, then en=1, bits 1,0,1,0,1 -> seq_out high in the cycle after bit 3 and after bit 5; match_cnt=2; crnt_state sequence 1,2,3,2,3.
2. OVERLAP=0, same stream 1,0,1,0,1 -> one match only, after bit 3; match_cnt=1; a further 0,1 stream yields the second match after bit 7.
3. MEALY=1, SEQ_LEN=4, PATTERN=4'b1101, overlap; bits 1,1,1,0,1,1,0,1 -> seq_out high combinationally on bits 5 and 8; crnt_state 1,2,2,3,1,2,3,1; match_cnt=2.
4. en gaps: stream 1,0,1 with en low for 3 cycles between each bit -> state holds across the gaps; single match; Moore seq_out stays high through an en-low gap after the match.
5. Reset mid-pattern: after 1,0, assert reset low for 1 clk, then send 1 -> crnt_state=1 and no match; match_cnt=0.
6. CNT_W=2: 5 overlapping 101 matches -> match_cnt stops at 3; clr_cnt coinciding with a match -> match_cnt=0.
